// File: rtl/inst_queue_dual.sv
// Dual-issue instruction queue: buffers two-slot fetch beats and issues up to two entries per cycle.
// Optional macro IQ_BYPASS_EN lets a beat skip an empty queue and load the output registers directly.
module inst_queue_dual #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    branch_flag,
  input  logic                    inst_req_success,
  input  logic [ADDR_W-1:0]       pc_i,
  input  logic                    inst_data_ok,
  input  logic [2*DATA_W-1:0]     inst_i,
  input  logic [1:0]              inst_valid_i,
  input  logic                    stall_i,
  output logic [DATA_W-1:0]       inst0_o,
  output logic [DATA_W-1:0]       inst1_o,
  output logic [ADDR_W-1:0]       pc0_o,
  output logic [ADDR_W-1:0]       pc1_o,
  output logic                    valid0_o,
  output logic                    valid1_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    ibuffer_full,
  output logic                    overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("inst_queue_dual: DEPTH must be a power of two and at least 4");
  end

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] inst_q [2];
  logic [DATA_W-1:0] inst_d [2];
  logic [ADDR_W-1:0] pc_q [2];
  logic [ADDR_W-1:0] pc_d [2];
  logic [1:0]        valid_q, valid_d;

  logic              kill;
  logic              beat_live;
  logic              fits;
  logic              bypass;
  logic              do_write;
  logic              drop;
  logic [1:0]        wr_pop;
  logic [1:0]        wr_cnt;
  logic [1:0]        iss_cnt;
  logic [CNT_W-1:0]  free_cnt;

  logic [1:0]        wr_en;
  logic [PTR_W-1:0]  wr_idx  [2];
  logic [DATA_W-1:0] wr_inst [2];
  logic [ADDR_W-1:0] wr_pc   [2];
  logic [PTR_W-1:0]  rd_idx  [2];
  logic [DATA_W-1:0] rd_inst [2];
  logic [ADDR_W-1:0] rd_pc   [2];

  assign kill      = flush | branch_flag;
  assign wr_pop    = {1'b0, inst_valid_i[0]} + {1'b0, inst_valid_i[1]};
  assign free_cnt  = CNT_W'(DEPTH) - count_q;
  assign beat_live = inst_data_ok & ~discard_q & ~kill & (wr_pop != 2'd0);
  assign fits      = free_cnt >= CNT_W'(wr_pop);

`ifdef IQ_BYPASS_EN
  assign bypass = beat_live & (count_q == '0) & ~stall_i;
`else
  assign bypass = 1'b0;
`endif

  assign do_write = beat_live & fits & ~bypass;
  assign drop     = beat_live & ~fits;
  assign wr_cnt   = do_write ? wr_pop : 2'd0;
  assign iss_cnt  = (stall_i | kill) ? 2'd0 :
                    (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign wr_idx[gi]  = tail_q + PTR_W'(gi);
    assign rd_idx[gi]  = head_q + PTR_W'(gi);
    assign rd_inst[gi] = inst_mem[rd_idx[gi]];
    assign rd_pc[gi]   = pc_mem[rd_idx[gi]];
  end

  // Lane 0 picks slot1 only for the illegal 2'b10 pattern, so that beat still lands as one entry.
  assign wr_inst[0] = inst_valid_i[0] ? inst_i[DATA_W-1:0] : inst_i[2*DATA_W-1:DATA_W];
  assign wr_pc[0]   = inst_valid_i[0] ? req_addr_q : req_addr_q + ADDR_W'(4);
  assign wr_inst[1] = inst_i[2*DATA_W-1:DATA_W];
  assign wr_pc[1]   = req_addr_q + ADDR_W'(4);
  assign wr_en[0]   = do_write;
  assign wr_en[1]   = do_write & (wr_pop == 2'd2);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        inst_mem[wr_idx[i]] <= wr_inst[i];
        pc_mem[wr_idx[i]]   <= wr_pc[i];
      end
    end
  end

  always_comb begin
    head_d     = head_q + PTR_W'(iss_cnt);
    tail_d     = tail_q + PTR_W'(wr_cnt);
    count_d    = count_q + CNT_W'(wr_cnt) - CNT_W'(iss_cnt);
    discard_d  = discard_q;
    req_addr_d = inst_req_success ? pc_i : req_addr_q;
    overflow_d = drop;
    inst_d     = inst_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (kill) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      discard_d = 1'b1;
      valid_d   = '0;
      for (int i = 0; i < 2; i++) begin
        inst_d[i] = '0;
        pc_d[i]   = '0;
      end
    end else begin
      // Data for a killed request may still return; only a fresh accepted request reopens the gate.
      if (inst_req_success) discard_d = 1'b0;
      if (bypass) begin
        valid_d = {wr_pop == 2'd2, 1'b1};
        for (int i = 0; i < 2; i++) begin
          inst_d[i] = valid_d[i] ? wr_inst[i] : '0;
          pc_d[i]   = valid_d[i] ? wr_pc[i]   : '0;
        end
      end else if (!stall_i) begin
        for (int i = 0; i < 2; i++) begin
          valid_d[i] = iss_cnt > 2'(i);
          inst_d[i]  = valid_d[i] ? rd_inst[i] : '0;
          pc_d[i]    = valid_d[i] ? rd_pc[i]   : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
      req_addr_q <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      req_addr_q <= req_addr_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= inst_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

  assign inst0_o      = inst_q[0];
  assign inst1_o      = inst_q[1];
  assign pc0_o        = pc_q[0];
  assign pc1_o        = pc_q[1];
  assign valid0_o     = valid_q[0];
  assign valid1_o     = valid_q[1];
  assign count_o      = count_q;
  assign ibuffer_full = free_cnt < CNT_W'(2);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_inst_queue_dual.sv
// Directed bench for inst_queue_dual: a vector table for single-cycle behaviour plus
// hand-written sequences for overflow, stall/flush, discard, pointer wrap and reset.
module tb_inst_queue_dual;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        branch_flag;
  logic        inst_req_success;
  logic [31:0] pc_i;
  logic        inst_data_ok;
  logic [63:0] inst_i;
  logic [1:0]  inst_valid_i;
  logic        stall_i;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        valid0_o, valid1_o;
  logic [4:0]  count_o;
  logic        ibuffer_full;
  logic        overflow_o;

  int checks   = 0;
  int failures = 0;

  inst_queue_dual dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .branch_flag      (branch_flag),
    .inst_req_success (inst_req_success),
    .pc_i             (pc_i),
    .inst_data_ok     (inst_data_ok),
    .inst_i           (inst_i),
    .inst_valid_i     (inst_valid_i),
    .stall_i          (stall_i),
    .inst0_o          (inst0_o),
    .inst1_o          (inst1_o),
    .pc0_o            (pc0_o),
    .pc1_o            (pc1_o),
    .valid0_o         (valid0_o),
    .valid1_o         (valid1_o),
    .count_o          (count_o),
    .ibuffer_full     (ibuffer_full),
    .overflow_o       (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, br, req;
    logic [31:0] pc;
    logic        dok;
    logic [63:0] inst;
    logic [1:0]  vld;
    logic        st;
    logic        v0, v1;
    logic [31:0] i0, p0, i1, p1;
    logic [4:0]  cnt;
    logic        full, ovf;
  } vec_t;

  function automatic vec_t mk(input logic fl, br, req, input logic [31:0] pc,
                              input logic dok, input logic [63:0] inst, input logic [1:0] vld,
                              input logic st, input logic v0, v1,
                              input logic [31:0] i0, p0, i1, p1,
                              input logic [4:0] cnt, input logic full, ovf);
    vec_t v;
    v.fl = fl; v.br = br; v.req = req; v.pc = pc; v.dok = dok; v.inst = inst;
    v.vld = vld; v.st = st; v.v0 = v0; v.v1 = v1; v.i0 = i0; v.p0 = p0;
    v.i1 = i1; v.p1 = p1; v.cnt = cnt; v.full = full; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic fl, br, req, input logic [31:0] pc, input logic dok,
                     input logic [63:0] inst, input logic [1:0] vld, input logic st);
    @(negedge clk);
    flush = fl; branch_flag = br; inst_req_success = req; pc_i = pc;
    inst_data_ok = dok; inst_i = inst; inst_valid_i = vld; stall_i = st;
    @(posedge clk);
    #1;
    $display("txn t=%0t fl=%b br=%b req=%b dok=%b vld=%b st=%b -> v=%b%b i0=%h p0=%h i1=%h p1=%h cnt=%0d",
             $time, fl, br, req, dok, vld, st, valid0_o, valid1_o, inst0_o, pc0_o, inst1_o, pc1_o, count_o);
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00, st);
  endtask

  task automatic beat(input logic [63:0] inst, input logic [1:0] vld, input logic st);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, inst, vld, st);
  endtask

  task automatic req(input logic [31:0] pc, input logic st);
    cyc(1'b0, 1'b0, 1'b1, pc, 1'b0, 64'h0, 2'b00, st);
  endtask

  task automatic expect_out(input string tag, input logic v0, v1,
                            input logic [31:0] i0, p0, i1, p1, input logic [4:0] cnt);
    chk({tag, ".valid0"}, valid0_o, v0);
    chk({tag, ".valid1"}, valid1_o, v1);
    chk({tag, ".inst0"},  inst0_o, i0);
    chk({tag, ".pc0"},    pc0_o, p0);
    chk({tag, ".inst1"},  inst1_o, i1);
    chk({tag, ".pc1"},    pc1_o, p1);
    chk({tag, ".count"},  count_o, cnt);
  endtask

  vec_t vecs [16];
  logic [31:0] exp_pc;
  logic [31:0] beat_pc;
  int issued;

  initial begin
    reset = 1'b1; flush = 1'b0; branch_flag = 1'b0; inst_req_success = 1'b0;
    pc_i = '0; inst_data_ok = 1'b0; inst_i = '0; inst_valid_i = '0; stall_i = 1'b0;

    // fl br req pc dok inst vld st | v0 v1 i0 p0 i1 p1 cnt full ovf
    vecs[0]  = mk(0,0,1,32'hBFC0_0000,0,64'h0,2'b00,0, 0,0,0,0,0,0, 0,0,0);
`ifdef IQ_BYPASS_EN
    vecs[1]  = mk(0,0,0,0,1,{32'h2,32'h1},2'b11,0, 1,1,32'h1,32'hBFC0_0000,32'h2,32'hBFC0_0004, 0,0,0);
    vecs[2]  = mk(0,0,0,0,0,64'h0,2'b00,0, 0,0,0,0,0,0, 0,0,0);
`else
    vecs[1]  = mk(0,0,0,0,1,{32'h2,32'h1},2'b11,0, 0,0,0,0,0,0, 2,0,0);
    vecs[2]  = mk(0,0,0,0,0,64'h0,2'b00,0, 1,1,32'h1,32'hBFC0_0000,32'h2,32'hBFC0_0004, 0,0,0);
`endif
    vecs[3]  = mk(0,0,1,32'h100,0,64'h0,2'b00,0, 0,0,0,0,0,0, 0,0,0);
    vecs[4]  = mk(0,0,0,0,1,{32'h22,32'h11},2'b01,1, 0,0,0,0,0,0, 1,0,0);
    vecs[5]  = mk(0,0,0,0,1,{32'h99,32'h33},2'b01,1, 0,0,0,0,0,0, 2,0,0);
    vecs[6]  = mk(0,0,0,0,0,64'h0,2'b00,0, 1,1,32'h11,32'h100,32'h33,32'h100, 0,0,0);
    vecs[7]  = mk(0,0,0,0,0,64'h0,2'b00,0, 0,0,0,0,0,0, 0,0,0);
    vecs[8]  = mk(0,0,0,0,1,{32'h0,32'h44},2'b01,1, 0,0,0,0,0,0, 1,0,0);
    vecs[9]  = mk(0,0,0,0,0,64'h0,2'b00,0, 1,0,32'h44,32'h100,0,0, 0,0,0);
    vecs[10] = mk(0,0,0,0,1,{32'h66,32'h55},2'b11,1, 1,0,32'h44,32'h100,0,0, 2,0,0);
    vecs[11] = mk(0,0,0,0,1,{32'h88,32'h77},2'b11,0, 1,1,32'h55,32'h100,32'h66,32'h104, 2,0,0);
    vecs[12] = mk(0,0,0,0,0,64'h0,2'b00,0, 1,1,32'h77,32'h100,32'h88,32'h104, 0,0,0);
    vecs[13] = mk(0,0,1,32'hFFFF_FFFC,0,64'h0,2'b00,1, 1,1,32'h77,32'h100,32'h88,32'h104, 0,0,0);
    vecs[14] = mk(0,0,0,0,1,{32'hBB,32'hAA},2'b11,1, 1,1,32'h77,32'h100,32'h88,32'h104, 2,0,0);
    vecs[15] = mk(0,0,0,0,0,64'h0,2'b00,0, 1,1,32'hAA,32'hFFFF_FFFC,32'hBB,32'h0, 0,0,0);

    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.full", ibuffer_full, 1'b0);
    chk("reset.ovf", overflow_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].fl, vecs[i].br, vecs[i].req, vecs[i].pc, vecs[i].dok,
          vecs[i].inst, vecs[i].vld, vecs[i].st);
      expect_out($sformatf("vec%0d", i), vecs[i].v0, vecs[i].v1, vecs[i].i0, vecs[i].p0,
                 vecs[i].i1, vecs[i].p1, vecs[i].cnt);
      chk($sformatf("vec%0d.full", i), ibuffer_full, vecs[i].full);
      chk($sformatf("vec%0d.ovf", i), overflow_o, vecs[i].ovf);
    end

    // Fill to 15 under stall, then overflow a two-slot beat.
    req(32'h2000, 1'b1);
    for (int k = 0; k < 7; k++) beat({32'h101 + 32'(2*k), 32'h100 + 32'(2*k)}, 2'b11, 1'b1);
    chk("fill14.count", count_o, 5'd14);
    chk("fill14.full", ibuffer_full, 1'b0);
    beat({32'h0, 32'h10E}, 2'b01, 1'b1);
    chk("fill15.count", count_o, 5'd15);
    chk("fill15.full", ibuffer_full, 1'b1);
    chk("fill15.ovf", overflow_o, 1'b0);
    beat({32'hDEAD, 32'hBEEF}, 2'b11, 1'b1);
    chk("ovf.pulse", overflow_o, 1'b1);
    chk("ovf.count", count_o, 5'd15);
    idle(1'b1);
    chk("ovf.clear", overflow_o, 1'b0);
    chk("ovf.count2", count_o, 5'd15);

    // Issue once, hold under stall, then flush during stall.
    idle(1'b0);
    expect_out("issue1", 1, 1, 32'h100, 32'h2000, 32'h101, 32'h2004, 13);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      expect_out($sformatf("stall%0d", k), 1, 1, 32'h100, 32'h2000, 32'h101, 32'h2004, 13);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00, 1'b1);
    expect_out("flush", 0, 0, 0, 0, 0, 0, 0);
    chk("flush.full", ibuffer_full, 1'b0);

    // Discard window after flush, then branch with a coincident beat.
    beat({32'h2, 32'h1}, 2'b11, 1'b1);
    chk("discard.count", count_o, 5'd0);
    req(32'h3000, 1'b1);
    beat({32'h202, 32'h201}, 2'b11, 1'b1);
    beat({32'h204, 32'h203}, 2'b11, 1'b1);
    beat({32'h0, 32'h205}, 2'b01, 1'b1);
    chk("br_pre.count", count_o, 5'd5);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, {32'h207, 32'h206}, 2'b11, 1'b0);
    expect_out("branch", 0, 0, 0, 0, 0, 0, 0);
    beat({32'h209, 32'h208}, 2'b11, 1'b1);
    chk("br_ign.count", count_o, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h4000, 1'b1, {32'h20B, 32'h20A}, 2'b11, 1'b1);
    chk("br_reqcycle.count", count_o, 5'd0);
    beat({32'h302, 32'h301}, 2'b11, 1'b1);
    chk("br_accept.count", count_o, 5'd2);
    idle(1'b0);
    expect_out("br_issue", 1, 1, 32'h301, 32'h4000, 32'h302, 32'h4004, 0);

    // Streaming: a request and a two-slot beat every cycle, PCs must come out gap-free.
    exp_pc = 32'h0001_0000;
    issued = 0;
    for (int c = 0; c < 44; c++) begin
      beat_pc = 32'h0001_0000 + 32'(8 * (c - 1));
      cyc(1'b0, 1'b0, c < 40, 32'h0001_0000 + 32'(8 * c), (c >= 1) && (c <= 40),
          {beat_pc + 32'h4, beat_pc}, 2'b11, 1'b0);
      chk($sformatf("wrap%0d.ovf", c), overflow_o, 1'b0);
      if (valid0_o) begin
        chk($sformatf("wrap%0d.pc0", c), pc0_o, exp_pc);
        chk($sformatf("wrap%0d.inst0", c), inst0_o, exp_pc);
        exp_pc = exp_pc + 32'h4;
        issued++;
      end
      if (valid1_o) begin
        chk($sformatf("wrap%0d.pc1", c), pc1_o, exp_pc);
        chk($sformatf("wrap%0d.inst1", c), inst1_o, exp_pc);
        exp_pc = exp_pc + 32'h4;
        issued++;
      end
    end
    chk("wrap.issued", issued, 80);
    chk("wrap.count", count_o, 5'd0);

    // Mid-operation reset, and reset clearing discard and the request address.
    beat({32'h502, 32'h501}, 2'b11, 1'b1);
    chk("pre_rst.count", count_o, 5'd2);
    @(negedge clk);
    reset = 1'b1;
    idle(1'b1);
    expect_out("midrst", 0, 0, 0, 0, 0, 0, 0);
    chk("midrst.ovf", overflow_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 2'b00, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    idle(1'b1);
    @(negedge clk);
    reset = 1'b0;
    beat({32'h602, 32'h601}, 2'b11, 1'b1);
    chk("post_rst.count", count_o, 5'd2);
    idle(1'b0);
    expect_out("post_rst", 1, 1, 32'h601, 32'h0, 32'h602, 32'h4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
